// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory access path.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam logic [15:0] IO_HEX_ADDR = 16'hFFFF;
  localparam int unsigned CNT_W       = 3;

  function automatic logic is_io_addr(input logic [15:0] addr);
    return addr == IO_HEX_ADDR;
  endfunction

endpackage

// File: rtl/lc3_mmio.sv
// Memory-mapped I/O for the LC-3: address decode, hex-display register and
// the read-data path that selects switches or RAM.
module lc3_mmio
  import lc3_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  output logic        is_io_o,
  input  logic        io_sel_i,
  input  logic [15:0] sw_i,
  input  logic [15:0] ram_rdata_i,
  output logic [15:0] rd_data_o,
  input  logic        hex_we_i,
  input  logic [15:0] hex_wdata_i,
  output logic [15:0] hex_out_o
);

  logic [15:0] hex_q;

  assign is_io_o   = is_io_addr(addr_i);
  assign rd_data_o = io_sel_i ? sw_i : ram_rdata_i;
  assign hex_out_o = hex_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hex_q <= '0;
    end else if (hex_we_i) begin
      hex_q <= hex_wdata_i;
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access sequencer: captures a request, waits WAIT_CYCLES extra
// cycles against a synchronous RAM or the MMIO block, then pulses R.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [15:0] hex_out
);

  mem_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        addr_q, wdata_q, mdr_in_q;
  logic               ram_we_q, op_we_q, io_q;
  logic               capture, finish;
  logic               mar_is_io;
  logic [15:0]        rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          capture = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ram_we_q <= 1'b0;
      op_we_q  <= 1'b0;
      io_q     <= 1'b0;
      mdr_in_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Write strobe only lives for the first ACCESS cycle.
      ram_we_q <= capture & MEM_WE & ~mar_is_io;
      if (capture) begin
        addr_q  <= MAR;
        wdata_q <= MDR;
        op_we_q <= MEM_WE;
        io_q    <= mar_is_io;
      end
      if (finish && !op_we_q) begin
        mdr_in_q <= rd_data;
      end
    end
  end

  lc3_mmio u_mmio (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .addr_i      (MAR),
    .is_io_o     (mar_is_io),
    .io_sel_i    (io_q),
    .sw_i        (SW),
    .ram_rdata_i (ram_rdata),
    .rd_data_o   (rd_data),
    .hex_we_i    (finish & op_we_q & io_q),
    .hex_wdata_i (wdata_q),
    .hex_out_o   (hex_out)
  );

  assign R         = (state_q == DONE);
  assign MDR_In    = mdr_in_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = ram_we_q;

endmodule
